// File: rtl/dmem_port_arbiter.sv
// Shares one single-port data memory between the CPU MEM stage (fixed priority) and a DMA engine; optional ARB_STATS_EN adds stall/grant counters.
// Zero-cycle grant and read, writes commit at the closing edge; the loser sees cpu_stall=1 or dma_ack=0 and holds its request.
module dmem_port_arbiter #(
  parameter int AW           = 9,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 8,
  parameter int BURST_MAX    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_wen,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  output logic [DW-1:0] cpu_dout,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_wen,
  input  logic          dma_lock,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_din,
  output logic [DW-1:0] dma_dout,
  output logic          dma_ack,
`ifdef ARB_STATS_EN
  output logic [15:0]   stat_stall_cnt,
  output logic [15:0]   stat_dma_cnt,
`endif
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [SW-1:0] STARVE_SAT = SW'(STARVE_LIMIT);
  localparam logic [BW-1:0] BEAT_LAST  = BW'(BURST_MAX);
  localparam bit BURST_EN = (BURST_MAX > 1);

  typedef enum logic {IDLE, BURST} state_t;

  typedef struct packed {
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
  } mem_req_t;

  state_t        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [BW-1:0] beat_q, beat_d, beat_inc;
  logic          cool_q, cool_d;
  logic          force_dma, gnt_dma;
  mem_req_t      cpu_side, dma_side, port;

  // The cool cycle after a full burst hands the port back to the CPU even if DMA is starving.
  always_comb begin
    force_dma = (starve_q == STARVE_SAT);
    gnt_dma   = 1'b0;
    if (state_q == BURST) gnt_dma = dma_req;
    else                  gnt_dma = dma_req & (~cpu_req | (force_dma & ~cool_q));
  end

  always_comb begin
    cpu_side = '{wen: cpu_req & cpu_wen, addr: cpu_addr, din: cpu_din};
    dma_side = '{wen: dma_wen, addr: dma_addr, din: dma_din};
    port     = gnt_dma ? dma_side : cpu_side;
  end

  assign mem_wen   = port.wen & ~rst;
  assign mem_addr  = port.addr;
  assign mem_din   = port.din;
  assign dma_ack   = gnt_dma & ~rst;
  assign cpu_stall = cpu_req & gnt_dma & ~rst;
  assign cpu_dout  = mem_dout;
  assign dma_dout  = mem_dout;

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    cool_d   = 1'b0;
    starve_d = '0;
    beat_inc = beat_q + 1'b1;
    if (dma_req && !gnt_dma) starve_d = force_dma ? starve_q : starve_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (BURST_EN && gnt_dma && dma_lock && !cool_q) begin
          state_d = BURST;
          beat_d  = BW'(1);
        end
      end
      BURST: begin
        if (!dma_req) begin
          state_d = IDLE;
          beat_d  = '0;
        end else if (beat_inc == BEAT_LAST) begin
          state_d = IDLE;
          beat_d  = '0;
          cool_d  = 1'b1;
        end else if (!dma_lock) begin
          state_d = IDLE;
          beat_d  = '0;
        end else begin
          beat_d  = beat_inc;
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
      beat_q   <= '0;
      cool_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      beat_q   <= beat_d;
      cool_q   <= cool_d;
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_stall_cnt <= '0;
      stat_dma_cnt   <= '0;
    end else begin
      if (cpu_stall && stat_stall_cnt != 16'hFFFF) stat_stall_cnt <= stat_stall_cnt + 16'd1;
      if (dma_ack && stat_dma_cnt != 16'hFFFF)     stat_dma_cnt   <= stat_dma_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: vector table, hand-written starvation/burst/reset sequences and random traffic against a queue-free reference model.
module tb_dmem_port_arbiter;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int SL = 8;
  localparam int BM = 4;

  logic clk = 1'b0;
  logic rst;
  logic cpu_req, cpu_wen, dma_req, dma_wen, dma_lock;
  logic [AW-1:0] cpu_addr, dma_addr, mem_addr;
  logic [DW-1:0] cpu_din, dma_din, cpu_dout, dma_dout, mem_din, mem_dout;
  logic cpu_stall, dma_ack, mem_wen;
`ifdef ARB_STATS_EN
  logic [15:0] stat_stall_cnt, stat_dma_cnt;
`endif

  logic [DW-1:0] mem    [512];
  logic [DW-1:0] shadow [512];

  int vecs = 0;
  int errs = 0;
  int m_blocked, m_beats, m_stall_n, m_dma_n;
  bit m_cool;

  dmem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(SL), .BURST_MAX(BM)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_wen(dma_wen), .dma_lock(dma_lock), .dma_addr(dma_addr),
    .dma_din(dma_din), .dma_dout(dma_dout), .dma_ack(dma_ack),
`ifdef ARB_STATS_EN
    .stat_stall_cnt(stat_stall_cnt), .stat_dma_cnt(stat_dma_cnt),
`endif
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  assign mem_dout = mem[mem_addr];
  always @(posedge clk) if (mem_wen) mem[mem_addr] = mem_din;

  function automatic logic [31:0] init_word(input int i);
    if (i == 72) return 32'h01000000;
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit creq, input bit cwen, input logic [8:0] caddr, input logic [31:0] cdin,
                       input bit dreq, input bit dwen, input bit dlock, input logic [8:0] daddr,
                       input logic [31:0] ddin);
    @(negedge clk);
    cpu_req = creq; cpu_wen = cwen; cpu_addr = caddr; cpu_din = cdin;
    dma_req = dreq; dma_wen = dwen; dma_lock = dlock; dma_addr = daddr; dma_din = ddin;
    #1;
  endtask

  // DMA wins when bursting, when the CPU is absent, or when it has waited SL cycles outside a cool cycle.
  function automatic bit model_gnt();
    if (m_beats > 0) return dma_req;
    return dma_req && (!cpu_req || (m_blocked >= SL && !m_cool));
  endfunction

  task automatic model_reset();
    m_blocked = 0; m_beats = 0; m_cool = 1'b0; m_stall_n = 0; m_dma_n = 0;
  endtask

  task automatic model_check();
    bit g;
    g = model_gnt();
    check("dma_ack", dma_ack, g);
    check("cpu_stall", cpu_stall, cpu_req && g);
    check("mem_wen", mem_wen, g ? dma_wen : (cpu_req && cpu_wen));
    check("mem_addr", mem_addr, g ? dma_addr : cpu_addr);
    check("mem_din", mem_din, g ? dma_din : cpu_din);
    if (g) check("dma_dout", dma_dout, shadow[dma_addr]);
    else if (cpu_req) check("cpu_dout", cpu_dout, shadow[cpu_addr]);
  endtask

  task automatic model_update();
    bit g;
    bit next_cool;
    g = model_gnt();
    next_cool = 1'b0;
    if (g && dma_wen) shadow[dma_addr] = dma_din;
    else if (!g && cpu_req && cpu_wen) shadow[cpu_addr] = cpu_din;
    if (g && cpu_req) m_stall_n++;
    if (g) m_dma_n++;
    if (dma_req && !g) m_blocked = (m_blocked < SL) ? m_blocked + 1 : SL;
    else m_blocked = 0;
    if (m_beats > 0) begin
      if (!dma_req) m_beats = 0;
      else begin
        m_beats++;
        if (m_beats == BM) begin
          m_beats = 0;
          next_cool = 1'b1;
        end else if (!dma_lock) m_beats = 0;
      end
    end else if (g && dma_lock && !m_cool && BM > 1) m_beats = 1;
    m_cool = next_cool;
  endtask

  task automatic cycle(input bit creq, input bit cwen, input logic [8:0] caddr, input logic [31:0] cdin,
                       input bit dreq, input bit dwen, input bit dlock, input logic [8:0] daddr,
                       input logic [31:0] ddin);
    drive(creq, cwen, caddr, cdin, dreq, dwen, dlock, daddr, ddin);
    model_check();
    model_update();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cpu_req = 0; cpu_wen = 0; dma_req = 0; dma_wen = 0; dma_lock = 0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit creq, cwen; logic [8:0] caddr; logic [31:0] cdin;
    bit dreq, dwen, dlock; logic [8:0] daddr; logic [31:0] ddin;
    bit e_ack, e_stall, e_wen; logic [8:0] e_addr; bit rd_chk; logic [31:0] e_rd;
  } vec_t;

  vec_t tbl [8];

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem[i] = init_word(i);
      shadow[i] = init_word(i);
    end
    tbl[0] = '{1'b1, 1'b1, 9'd5, 32'h28aed2a6, 1'b0, 1'b0, 1'b0, 9'd0, 32'h0,        1'b0, 1'b0, 1'b1, 9'd5,  1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 9'd5, 32'h0,        1'b0, 1'b0, 1'b0, 9'd0, 32'h0,        1'b0, 1'b0, 1'b0, 9'd5,  1'b1, 32'h28aed2a6};
    tbl[2] = '{1'b0, 1'b0, 9'd0, 32'h0,        1'b1, 1'b0, 1'b0, 9'd72, 32'h0,       1'b1, 1'b0, 1'b0, 9'd72, 1'b1, 32'h01000000};
    tbl[3] = '{1'b1, 1'b1, 9'd7, 32'hdeadbeef, 1'b1, 1'b0, 1'b0, 9'd72, 32'h0,       1'b0, 1'b0, 1'b1, 9'd7,  1'b0, 32'h0};
    tbl[4] = '{1'b0, 1'b0, 9'd0, 32'h0,        1'b1, 1'b1, 1'b0, 9'd9, 32'hcafef00d, 1'b1, 1'b0, 1'b1, 9'd9,  1'b0, 32'h0};
    tbl[5] = '{1'b1, 1'b0, 9'd9, 32'h0,        1'b0, 1'b0, 1'b0, 9'd0, 32'h0,        1'b0, 1'b0, 1'b0, 9'd9,  1'b1, 32'hcafef00d};
    tbl[6] = '{1'b1, 1'b0, 9'd7, 32'h0,        1'b0, 1'b0, 1'b1, 9'd3, 32'h0,        1'b0, 1'b0, 1'b0, 9'd7,  1'b1, 32'hdeadbeef};
    tbl[7] = '{1'b0, 1'b0, 9'd0, 32'h0,        1'b1, 1'b0, 1'b0, 9'd7, 32'h0,        1'b1, 1'b0, 1'b0, 9'd7,  1'b1, 32'hdeadbeef};

    // Reset holds every side effect low even with both requesters writing.
    rst = 1'b1;
    cpu_req = 1; cpu_wen = 1; cpu_addr = 9'd1; cpu_din = 32'h1;
    dma_req = 1; dma_wen = 1; dma_lock = 1; dma_addr = 9'd2; dma_din = 32'h2;
    #1;
    check("rst_mem_wen", mem_wen, 1'b0);
    check("rst_dma_ack", dma_ack, 1'b0);
    check("rst_cpu_stall", cpu_stall, 1'b0);
`ifdef ARB_STATS_EN
    check("rst_stat_stall", stat_stall_cnt, 16'd0);
    check("rst_stat_dma", stat_dma_cnt, 16'd0);
`endif
    do_reset();

    foreach (tbl[i]) begin
      cycle(tbl[i].creq, tbl[i].cwen, tbl[i].caddr, tbl[i].cdin,
            tbl[i].dreq, tbl[i].dwen, tbl[i].dlock, tbl[i].daddr, tbl[i].ddin);
      check($sformatf("tbl%0d_ack", i), dma_ack, tbl[i].e_ack);
      check($sformatf("tbl%0d_stall", i), cpu_stall, tbl[i].e_stall);
      check($sformatf("tbl%0d_wen", i), mem_wen, tbl[i].e_wen);
      check($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].e_addr);
      if (tbl[i].rd_chk) check($sformatf("tbl%0d_rd", i), tbl[i].e_ack ? dma_dout : cpu_dout, tbl[i].e_rd);
    end

    // Both requesting without lock: DMA forced every ninth cycle.
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      cycle(1'b1, 1'b0, 9'd5, 32'h0, 1'b1, 1'b0, 1'b0, 9'd72, 32'h0);
      check($sformatf("starve_ack_c%0d", c), dma_ack, (c == 9 || c == 18));
      check($sformatf("starve_stall_c%0d", c), cpu_stall, (c == 9 || c == 18));
    end
`ifdef ARB_STATS_EN
    check("stat_dma_cnt", stat_dma_cnt, 16'd2);
    check("stat_stall_cnt", stat_stall_cnt, 16'd2);
`endif

    // Locked: forced beat starts a 4-beat burst, one cool CPU cycle, then counting restarts.
    do_reset();
    for (int c = 1; c <= 24; c++) begin
      cycle(1'b1, 1'b0, 9'd3, 32'h0, 1'b1, 1'b0, 1'b1, 9'd72, 32'h0);
      check($sformatf("burst_ack_c%0d", c), dma_ack, (c >= 9 && c <= 12) || (c >= 21 && c <= 24));
    end

    // Reset during beat 2 of a write burst suppresses the write at once.
    do_reset();
    for (int c = 1; c <= 9; c++) cycle(1'b1, 1'b0, 9'd3, 32'h0, 1'b1, 1'b0, 1'b1, 9'd100, 32'h0);
    drive(1'b1, 1'b0, 9'd3, 32'h0, 1'b1, 1'b1, 1'b1, 9'd101, 32'h12345678);
    check("beat2_ack", dma_ack, 1'b1);
    check("beat2_wen", mem_wen, 1'b1);
    rst = 1'b1;
    #1;
    check("midburst_rst_wen", mem_wen, 1'b0);
    check("midburst_rst_ack", dma_ack, 1'b0);
    check("midburst_rst_stall", cpu_stall, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cycle(1'b1, 1'b0, 9'd3, 32'h0, 1'b1, 1'b0, 1'b1, 9'd100, 32'h0);
    check("post_rst_ack", dma_ack, 1'b0);
    check("post_rst_stall", cpu_stall, 1'b0);
    check("no_write_after_rst", mem[101], init_word(101));

    // Random traffic on a small address window so reads hit earlier writes.
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, 9'($urandom_range(0, 15)), 32'($urandom),
            $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 7,
            9'($urandom_range(0, 15)), 32'($urandom));
    end
    drive(1'b0, 1'b0, 9'd0, 32'h0, 1'b0, 1'b0, 1'b0, 9'd0, 32'h0);
`ifdef ARB_STATS_EN
    check("rand_stat_stall", stat_stall_cnt, 16'(m_stall_n));
    check("rand_stat_dma", stat_dma_cnt, 16'(m_dma_n));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
